// File: rtl/ysyx_25020047_ifu.sv
// Instruction fetch unit: one outstanding 32-bit fetch over a valid/ready memory port, word held until decode accepts.
// Latency: 4 cycles minimum per instruction; request held until req_ready, instruction held until inst_ready, no response back-pressure.
module ysyx_25020047_ifu #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_en,
    input  logic [31:0] pc,
    input  logic        flush,
    output logic        req_valid,
    output logic [31:0] req_addr,
    input  logic        req_ready,
    input  logic        rsp_valid,
    input  logic [31:0] rsp_data,
    input  logic        rsp_err,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ready,
    output logic        busy,
    output logic        err,
    output logic [1:0]  err_code,
    output logic [31:0] fetch_cnt
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_HOLD = 3'd3,
        S_ERR  = 3'd4
    } state_t;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t      state;
    state_t      state_nxt;
    logic        discard;
    logic [7:0]  tmo_cnt;
    logic        drop;
    logic        aligned;

    // A flush arriving in the same cycle as the response still kills it.
    assign drop    = discard | flush;
    assign aligned = (pc[1:0] == 2'b00);
    assign busy    = (state != S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (fetch_en) begin
                    state_nxt = aligned ? S_REQ : S_ERR;
                end
            end
            S_REQ: begin
                if (req_ready) begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (rsp_valid) begin
                    if (drop) begin
                        state_nxt = S_IDLE;
                    end else if (rsp_err) begin
                        state_nxt = S_ERR;
                    end else begin
                        state_nxt = S_HOLD;
                    end
                end else if (tmo_cnt == TMO_LAST) begin
                    state_nxt = S_ERR;
                end
            end
            S_HOLD: begin
                if (flush || inst_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            S_ERR:   state_nxt = S_ERR;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_valid  <= 1'b0;
            req_addr   <= 32'd0;
            inst_valid <= 1'b0;
            inst       <= 32'd0;
            inst_pc    <= 32'd0;
            discard    <= 1'b0;
            tmo_cnt    <= 8'd0;
            err        <= 1'b0;
            err_code   <= 2'b00;
            fetch_cnt  <= 32'd0;
        end else begin
            // Handshake flags are registered copies of the next-state decode.
            req_valid  <= (state_nxt == S_REQ);
            inst_valid <= (state_nxt == S_HOLD);

            if (state == S_IDLE && fetch_en && aligned) begin
                req_addr <= pc;
                inst_pc  <= pc;
            end

            if (state == S_WAIT && rsp_valid && !drop && !rsp_err) begin
                inst <= rsp_data;
            end

            if (state_nxt == S_IDLE) begin
                discard <= 1'b0;
            end else if ((state == S_REQ || state == S_WAIT) && flush) begin
                discard <= 1'b1;
            end

            if (state == S_REQ) begin
                tmo_cnt <= 8'd0;
            end else if (state == S_WAIT && !rsp_valid) begin
                tmo_cnt <= tmo_cnt + 8'd1;
            end

            if (state == S_HOLD && inst_ready && !flush) begin
                fetch_cnt <= fetch_cnt + 32'd1;
            end

            if (state != S_ERR && state_nxt == S_ERR) begin
                err <= 1'b1;
                if (state == S_IDLE) begin
                    err_code <= 2'b01;
                end else if (rsp_valid) begin
                    err_code <= 2'b11;
                end else begin
                    err_code <= 2'b10;
                end
            end
        end
    end

endmodule

// File: tb/tb_ysyx_25020047_ifu.sv
// Directed bench for the fetch unit: expected instructions queued at issue, checked by a monitor at delivery.
module tb_ysyx_25020047_ifu;

    logic        clk = 1'b0;
    logic        rst;
    always #5 clk = ~clk;

    logic        fetch_en, flush, req_ready, rsp_valid, rsp_err, inst_ready;
    logic [31:0] pc, rsp_data;
    logic        req_valid, inst_valid, busy, err;
    logic [31:0] req_addr, inst, inst_pc, fetch_cnt;
    logic [1:0]  err_code;

    logic        t_fetch_en, t_flush, t_req_ready, t_rsp_valid, t_rsp_err, t_inst_ready;
    logic [31:0] t_pc, t_rsp_data;
    logic        t_req_valid, t_inst_valid, t_busy, t_err;
    logic [31:0] t_req_addr, t_inst, t_inst_pc, t_fetch_cnt;
    logic [1:0]  t_err_code;

    ysyx_25020047_ifu #(.TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .fetch_en(fetch_en), .pc(pc), .flush(flush),
        .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc), .inst_ready(inst_ready),
        .busy(busy), .err(err), .err_code(err_code), .fetch_cnt(fetch_cnt)
    );

    ysyx_25020047_ifu #(.TIMEOUT(4)) dut_to (
        .clk(clk), .rst(rst), .fetch_en(t_fetch_en), .pc(t_pc), .flush(t_flush),
        .req_valid(t_req_valid), .req_addr(t_req_addr), .req_ready(t_req_ready),
        .rsp_valid(t_rsp_valid), .rsp_data(t_rsp_data), .rsp_err(t_rsp_err),
        .inst_valid(t_inst_valid), .inst(t_inst), .inst_pc(t_inst_pc), .inst_ready(t_inst_ready),
        .busy(t_busy), .err(t_err), .err_code(t_err_code), .fetch_cnt(t_fetch_cnt)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
    } exp_t;

    exp_t sbq[$];
    int   vecs = 0;
    int   errs = 0;
    int   req_hs = 0;
    int   exp_cnt = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // fl: 0 none, 1 flush in REQ, 2 flush in WAIT, 3 flush in HOLD with inst_ready
    task automatic do_fetch(input logic [31:0] a, input logic [31:0] d, input int req_st,
                            input int rsp_st, input int rdy_st, input int fl, input logic re);
        int hs0;
        hs0 = req_hs;
        pc = a;
        fetch_en = 1'b1;
        step();
        fetch_en = 1'b0;
        pc = 32'h0;
        chk("req_valid", 32'(req_valid), 32'd1);
        chk("req_addr", req_addr, a);
        if (fl == 1) flush = 1'b1;
        for (int i = 0; i < req_st; i++) begin
            step();
            flush = 1'b0;
            chk("req_stall_valid", 32'(req_valid), 32'd1);
            chk("req_stall_addr", req_addr, a);
        end
        req_ready = 1'b1;
        step();
        req_ready = 1'b0;
        flush = 1'b0;
        chk("req_handshakes", 32'(req_hs - hs0), 32'd1);
        chk("wait_req_valid", 32'(req_valid), 32'd0);
        if (fl == 2) flush = 1'b1;
        for (int i = 0; i < rsp_st; i++) begin
            step();
            flush = 1'b0;
        end
        rsp_valid = 1'b1;
        rsp_data = d;
        rsp_err = re;
        step();
        rsp_valid = 1'b0;
        rsp_err = 1'b0;
        flush = 1'b0;
        if (fl == 1 || fl == 2) begin
            chk("drop_busy", 32'(busy), 32'd0);
            chk("drop_inst_valid", 32'(inst_valid), 32'd0);
            chk("drop_fetch_cnt", fetch_cnt, 32'(exp_cnt));
            return;
        end
        if (re) begin
            chk("rsperr_err", 32'(err), 32'd1);
            chk("rsperr_code", 32'(err_code), 32'd3);
            for (int i = 0; i < 2; i++) begin
                chk("rsperr_inst_valid", 32'(inst_valid), 32'd0);
                step();
            end
            return;
        end
        chk("hold_inst_valid", 32'(inst_valid), 32'd1);
        if (fl != 3) sbq.push_back('{pc: a, ins: d});
        for (int i = 0; i < rdy_st; i++) begin
            step();
            chk("hold_inst", inst, d);
            chk("hold_inst_pc", inst_pc, a);
            chk("hold_valid", 32'(inst_valid), 32'd1);
        end
        inst_ready = 1'b1;
        flush = (fl == 3);
        step();
        inst_ready = 1'b0;
        flush = 1'b0;
        if (fl != 3) exp_cnt++;
        chk("done_busy", 32'(busy), 32'd0);
        chk("done_inst_valid", 32'(inst_valid), 32'd0);
        chk("done_fetch_cnt", fetch_cnt, 32'(exp_cnt));
    endtask

    initial begin
        rst = 1'b1;
        {fetch_en, flush, req_ready, rsp_valid, rsp_err, inst_ready} = '0;
        pc = '0;
        rsp_data = '0;
        {t_fetch_en, t_flush, t_req_ready, t_rsp_valid, t_rsp_err, t_inst_ready} = '0;
        t_pc = '0;
        t_rsp_data = '0;
        fork
            forever begin
                exp_t e;
                @(negedge clk);
                if (!rst) begin
                    if (req_valid && req_ready) req_hs++;
                    if (inst_valid && inst_ready && !flush) begin
                        if (sbq.size() == 0) begin
                            vecs++;
                            errs++;
                            $display("FAIL unexpected_inst: got %h none expected", inst);
                        end else begin
                            e = sbq.pop_front();
                            chk("mon_inst", inst, e.ins);
                            chk("mon_inst_pc", inst_pc, e.pc);
                        end
                    end
                end
            end
            begin
                #200000;
                $display("FAIL watchdog: run still active at %0t", $time);
                $fatal(1, "watchdog expired");
            end
            begin
                repeat (2) @(posedge clk);
                #1;
                chk("rst_req_valid", 32'(req_valid), 32'd0);
                chk("rst_req_addr", req_addr, 32'd0);
                chk("rst_inst_valid", 32'(inst_valid), 32'd0);
                chk("rst_busy", 32'(busy), 32'd0);
                chk("rst_err", 32'(err), 32'd0);
                chk("rst_fetch_cnt", fetch_cnt, 32'd0);
                rst = 1'b0;
                step();

                do_fetch(32'h8000_0000, 32'h0010_0073, 0, 0, 0, 0, 1'b0);
                do_fetch(32'h8000_0004, 32'h0000_0513, 3, 5, 4, 0, 1'b0);
                do_fetch(32'h8000_0008, 32'hDEAD_BEEF, 2, 1, 0, 1, 1'b0);
                do_fetch(32'h8000_000C, 32'h0015_0513, 0, 0, 0, 0, 1'b0);
                do_fetch(32'h8000_0010, 32'h1234_5678, 0, 2, 0, 2, 1'b0);
                do_fetch(32'h8000_0014, 32'h0020_0593, 1, 1, 1, 0, 1'b0);
                do_fetch(32'h8000_0018, 32'hCAFE_F00D, 0, 0, 2, 3, 1'b0);
                do_fetch(32'h8000_001C, 32'h00B5_0633, 0, 0, 0, 0, 1'b0);

                pc = 32'h8000_0002;
                fetch_en = 1'b1;
                step();
                chk("mis_req_valid", 32'(req_valid), 32'd0);
                chk("mis_err", 32'(err), 32'd1);
                chk("mis_code", 32'(err_code), 32'd1);
                for (int i = 0; i < 4; i++) begin
                    fetch_en = i[0];
                    pc = 32'h8000_0000;
                    req_ready = 1'b1;
                    rsp_valid = 1'b1;
                    flush = i[1];
                    inst_ready = 1'b1;
                    step();
                    chk("err_hold_code", 32'(err_code), 32'd1);
                    chk("err_hold_req", 32'(req_valid), 32'd0);
                    chk("err_hold_inst", 32'(inst_valid), 32'd0);
                    chk("err_hold_busy", 32'(busy), 32'd1);
                end
                {fetch_en, flush, req_ready, rsp_valid, rsp_err, inst_ready} = '0;

                rst = 1'b1;
                #1;
                chk("rst2_err", 32'(err), 32'd0);
                chk("rst2_code", 32'(err_code), 32'd0);
                chk("rst2_fetch_cnt", fetch_cnt, 32'd0);
                chk("rst2_busy", 32'(busy), 32'd0);
                exp_cnt = 0;
                step();
                rst = 1'b0;
                step();

                do_fetch(32'h8000_0020, 32'h1234_5678, 0, 1, 0, 0, 1'b1);

                t_pc = 32'h0000_1000;
                t_fetch_en = 1'b1;
                step();
                t_fetch_en = 1'b0;
                chk("to_req_valid", 32'(t_req_valid), 32'd1);
                t_req_ready = 1'b1;
                step();
                t_req_ready = 1'b0;
                repeat (3) step();
                chk("to_not_yet_err", 32'(t_err), 32'd0);
                chk("to_not_yet_busy", 32'(t_busy), 32'd1);
                step();
                chk("to_err", 32'(t_err), 32'd1);
                chk("to_code", 32'(t_err_code), 32'd2);
                t_rsp_valid = 1'b1;
                t_rsp_data = 32'h0010_0073;
                t_inst_ready = 1'b1;
                step();
                t_rsp_valid = 1'b0;
                t_inst_ready = 1'b0;
                chk("late_inst_valid", 32'(t_inst_valid), 32'd0);
                chk("late_code", 32'(t_err_code), 32'd2);

                rst = 1'b1;
                #1;
                chk("to_rst_req_valid", 32'(t_req_valid), 32'd0);
                chk("to_rst_req_addr", t_req_addr, 32'd0);
                chk("to_rst_inst_valid", 32'(t_inst_valid), 32'd0);
                chk("to_rst_inst", t_inst, 32'd0);
                chk("to_rst_inst_pc", t_inst_pc, 32'd0);
                chk("to_rst_busy", 32'(t_busy), 32'd0);
                chk("to_rst_err", 32'(t_err), 32'd0);
                chk("to_rst_code", 32'(t_err_code), 32'd0);
                chk("to_rst_fetch_cnt", t_fetch_cnt, 32'd0);
                step();
                rst = 1'b0;
                step();
                chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
            end
        join_any
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/ysyx_25020047_ifu.md
# ysyx_25020047_ifu

Instruction fetch unit: the producing end of the instruction interface that the decode stage consumes. It takes the current PC from the PC unit, fetches one 32-bit instruction word over a valid/ready request/response memory port, and holds the word with its PC until the decode stage accepts it. It also handles flushes from downstream, misaligned PCs, memory errors and response timeouts.

## Interface
- TIMEOUT, default 255: maximum number of WAIT cycles without a response before a timeout error (range 2..255).
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- fetch_en  input  1  permits a new fetch from IDLE.
- pc  input  32  fetch address; sampled only on the IDLE->REQ transition.
- flush  input  1  discards the in-flight or held fetch.
- req_valid  output  1  memory request valid (registered).
- req_addr  output  32  memory request address (registered).
- req_ready  input  1  memory accepts the request.
- rsp_valid  input  1  memory response valid; there is no back-pressure on the response.
- rsp_data  input  32  instruction word.
- rsp_err  input  1  the response is an access fault.
- inst_valid  output  1  instruction available to decode.
- inst  output  32  instruction word.
- inst_pc  output  32  PC of `inst`.
- inst_ready  input  1  decode accepts `inst`.
- busy  output  1  high in every state except IDLE.
- err  output  1  sticky error flag; cleared only by rst.
- err_code  output  2  error cause: 00 none, 01 misaligned, 10 timeout, 11 rsp_err.
- fetch_cnt  output  32  count of instructions delivered; wraps modulo 2^32.

## Operation
- States: IDLE, REQ, WAIT, HOLD, ERR. All outputs are registered or decoded from the state.
- IDLE
  - fetch_en=1 and pc[1:0]=00: latch pc into req_addr and inst_pc, then go to REQ.
  - fetch_en=1 and pc[1:0]!=00: go to ERR with err_code=01. No request is issued.
  - fetch_en=0: stay in IDLE.
- REQ
  - req_valid=1. req_valid and req_addr stay stable until req_ready=1.
  - On req_valid & req_ready: go to WAIT, clear the timeout counter, clear req_valid.
- WAIT
  - On rsp_valid: if discard=0 and rsp_err=0, capture rsp_data into inst and go to HOLD.
  - On rsp_valid with discard=1: drop the word and go to IDLE, regardless of rsp_err.
  - On rsp_valid with rsp_err=1 and discard=0: go to ERR with err_code=11.
  - Without rsp_valid, the counter increments each cycle. When the counter equals TIMEOUT-1 and rsp_valid=0, go to ERR with err_code=10. This applies even when discard=1.
- HOLD
  - inst_valid=1. inst and inst_pc stay stable.
  - On inst_ready=1 and flush=0: increment fetch_cnt and go to IDLE.
- ERR
  - Terminal state: req_valid=0, inst_valid=0, err=1.
  - All inputs are ignored until rst.
- Flush handling
  - IDLE: no effect.
  - REQ: req_valid is held until the request is accepted (protocol rule), and the discard flag is set. On acceptance, go to WAIT with discard=1.
  - WAIT: set discard.
  - HOLD: clear inst_valid, go to IDLE, do not count the instruction. If inst_ready is high in the same cycle, flush wins and downstream ignores that transfer.
  - discard is cleared on entry to IDLE.
- Inputs ignored outside their state
  - rsp_valid is ignored in IDLE, REQ and HOLD. A response in those states is an upstream protocol violation and is not checked.
  - Memory is required to return the response no earlier than the cycle after the request is accepted.

## Timing
- Reset values
  - state=IDLE, discard=0, timeout counter=0.
  - req_valid=0, req_addr=0, inst_valid=0, inst=0, inst_pc=0.
  - busy=0, err=0, err_code=00, fetch_cnt=0.
- Reset asserted mid-operation returns everything to the reset values immediately, including any outstanding memory transaction state. The memory side is required to be reset together with this block.
- Zero-wait-state fetch sequence
  - C0: IDLE, fetch_en=1.
  - C1: REQ, req_valid=1, req_ready=1.
  - C2: WAIT, rsp_valid=1.
  - C3: HOLD, inst_valid=1, inst_ready=1.
  - C4: IDLE.
  - Result: one instruction per 4 cycles minimum. There is no pipelining and only one request is outstanding.
- The pc change produced by the PC unit after the C3 handshake is visible in C4 and is sampled in C4 when fetch_en=1.
- err and err_code assert in the cycle after the detecting condition.
- fetch_cnt updates in the cycle after the accepting handshake.

## Test plan
- Single fetch: pc=0x80000000, memory returns 0x00100073 with zero wait states.
  - Expect req_addr=0x80000000 in C1.
  - Expect inst_valid with inst=0x00100073 and inst_pc=0x80000000 in C3.
  - Expect fetch_cnt=1 in C4.
- Back-pressure: req_ready low for 3 cycles, rsp delayed 5 cycles, inst_ready low for 4 cycles.
  - Expect req_valid, req_addr, inst and inst_pc stable throughout.
  - Expect exactly one request handshake and one fetch_cnt increment.
- Flush cases, each with fetch_cnt unchanged and the next fetch proceeding normally:
  - Flush asserted in REQ: the request is still accepted, then the response 0xDEADBEEF is dropped and the block returns to IDLE.
  - Flush asserted in WAIT: the response is dropped and the block returns to IDLE.
  - Flush asserted in HOLD together with inst_ready: the instruction is discarded and the block returns to IDLE.
- Misaligned fetch: pc=0x80000002 with fetch_en=1.
  - Expect no req_valid, err=1 and err_code=01 next cycle.
  - Expect the block to stay in ERR while inputs toggle.
- Timeout: TIMEOUT=4, request accepted, rsp_valid never asserted.
  - Expect err_code=10 exactly 4 cycles after WAIT entry.
  - A late rsp_valid is ignored.
  - rst returns all outputs to their reset values.
- rsp_err=1 on a response: expect err_code=11 and inst_valid never asserted.
